// File: rtl/coralnpu_irq_ctrl.sv
// Interrupt aggregator: per-source edge/level gateways, fixed-priority claim/complete, registered irq and wfi wake pulse.
// Optional CORALNPU_IRQ_SYNC_EN adds a 2-flop synchronizer on every src bit for asynchronous sources.
module coralnpu_irq_ctrl #(
  parameter int unsigned NUM_SRC = 8,
  parameter int unsigned ID_W    = $clog2(NUM_SRC)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src,
  input  logic [NUM_SRC-1:0] edge_sel,
  input  logic [NUM_SRC-1:0] enable,
  output logic               claim_valid,
  output logic [ID_W-1:0]    claim_id,
  input  logic               claim_ready,
  input  logic               complete_valid,
  input  logic [ID_W-1:0]    complete_id,
  output logic [NUM_SRC-1:0] pending,
  output logic               irq,
  input  logic               wfi,
  output logic               wake
);

  logic [NUM_SRC-1:0] src_in;
  logic [NUM_SRC-1:0] src_prev;
  logic [NUM_SRC-1:0] in_service;
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] set_req;
  logic [NUM_SRC-1:0] claim_sel;
  logic [NUM_SRC-1:0] done_sel;
  logic               found;

`ifdef CORALNPU_IRQ_SYNC_EN
  logic [NUM_SRC-1:0] sync1;
  logic [NUM_SRC-1:0] sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= src;
      sync2 <= sync1;
    end
  end

  assign src_in = sync2;
`else
  assign src_in = src;
`endif

  always_comb begin
    eligible    = pending & enable & ~in_service;
    claim_valid = |eligible;
    claim_id    = '0;
    claim_sel   = '0;
    done_sel    = '0;
    set_req     = '0;
    found       = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (eligible[i] && !found) begin
        claim_id     = ID_W'(i);
        claim_sel[i] = claim_ready;
        found        = 1'b1;
      end
    end
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      done_sel[i] = complete_valid && (complete_id == ID_W'(i)) && in_service[i];
      // A level source being claimed this cycle counts as in service, so a held level does not re-pend.
      if (edge_sel[i])
        set_req[i] = src_in[i] & ~src_prev[i];
      else
        set_req[i] = src_in[i] & ~in_service[i] & ~claim_sel[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_prev   <= '0;
      pending    <= '0;
      in_service <= '0;
      irq        <= 1'b0;
      wake       <= 1'b0;
    end else begin
      src_prev   <= src_in;
      pending    <= (pending & ~claim_sel) | set_req;
      in_service <= (in_service | claim_sel) & ~done_sel;
      irq        <= |eligible;
      wake       <= ~irq & (|eligible) & wfi;
    end
  end

endmodule

// File: tb/tb_coralnpu_irq_ctrl.sv
// Directed self-checking bench for coralnpu_irq_ctrl (default build, NUM_SRC=8).
module tb_coralnpu_irq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] src;
  logic [7:0] edge_sel;
  logic [7:0] enable;
  logic       claim_valid;
  logic [2:0] claim_id;
  logic       claim_ready;
  logic       complete_valid;
  logic [2:0] complete_id;
  logic [7:0] pending;
  logic       irq;
  logic       wfi;
  logic       wake;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  coralnpu_irq_ctrl #(.NUM_SRC(8)) dut (
    .clk(clk), .rst(rst), .src(src), .edge_sel(edge_sel), .enable(enable),
    .claim_valid(claim_valid), .claim_id(claim_id), .claim_ready(claim_ready),
    .complete_valid(complete_valid), .complete_id(complete_id),
    .pending(pending), .irq(irq), .wfi(wfi), .wake(wake)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic claim_one();
    claim_ready = 1'b1; tick(); claim_ready = 1'b0;
  endtask

  task automatic complete_one(input logic [2:0] id);
    complete_valid = 1'b1; complete_id = id; tick(); complete_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; src = '0; edge_sel = '0; enable = 8'hFF; claim_ready = 1'b0;
    complete_valid = 1'b0; complete_id = '0; wfi = 1'b0;
    tick(); tick();
    checks++; if (pending !== 8'h00) begin failures++; $display("FAIL reset_pending got=%h exp=00", pending); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
    checks++; if (claim_valid !== 1'b0) begin failures++; $display("FAIL reset_claim_valid got=%b exp=0", claim_valid); end
    checks++; if (claim_id !== 3'd0) begin failures++; $display("FAIL reset_claim_id got=%0d exp=0", claim_id); end
    checks++; if (wake !== 1'b0) begin failures++; $display("FAIL reset_wake got=%b exp=0", wake); end
    @(negedge clk); rst = 1'b0;
    tick();
  endtask

  task automatic test_edge();
    edge_sel = 8'h08;
    src = 8'h08; tick(); src = '0;
    checks++; if (pending !== 8'h08) begin failures++; $display("FAIL edge_pending got=%h exp=08", pending); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL edge_irq_early got=%b exp=0", irq); end
    checks++; if (claim_id !== 3'd3) begin failures++; $display("FAIL edge_claim_id got=%0d exp=3", claim_id); end
    tick();
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL edge_irq got=%b exp=1", irq); end
    checks++; if (pending !== 8'h08) begin failures++; $display("FAIL edge_pending_hold got=%h exp=08", pending); end
    claim_one();
    checks++; if (pending !== 8'h00) begin failures++; $display("FAIL edge_claim_pending got=%h exp=00", pending); end
    checks++; if (claim_valid !== 1'b0) begin failures++; $display("FAIL edge_claim_valid got=%b exp=0", claim_valid); end
    tick();
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL edge_irq_drop got=%b exp=0", irq); end
    complete_one(3'd3);
    checks++; if (claim_valid !== 1'b0) begin failures++; $display("FAIL edge_idle got=%b exp=0", claim_valid); end
  endtask

  task automatic test_priority();
    edge_sel = 8'h00;
    src = 8'h24; tick();
    checks++; if (pending !== 8'h24) begin failures++; $display("FAIL prio_pending got=%h exp=24", pending); end
    checks++; if (claim_id !== 3'd2) begin failures++; $display("FAIL prio_first got=%0d exp=2", claim_id); end
    claim_one();
    checks++; if (claim_id !== 3'd5) begin failures++; $display("FAIL prio_second got=%0d exp=5", claim_id); end
    checks++; if (pending !== 8'h20) begin failures++; $display("FAIL prio_pending_after got=%h exp=20", pending); end
    complete_one(3'd2);
    checks++; if (claim_id !== 3'd5) begin failures++; $display("FAIL prio_after_complete got=%0d exp=5", claim_id); end
    tick();
    checks++; if (pending !== 8'h24) begin failures++; $display("FAIL prio_repend got=%h exp=24", pending); end
    checks++; if (claim_id !== 3'd2) begin failures++; $display("FAIL prio_reclaim got=%0d exp=2", claim_id); end
    src = '0;
    claim_one(); claim_one();
    complete_one(3'd2); complete_one(3'd5);
    checks++; if (pending !== 8'h00 || claim_valid !== 1'b0) begin failures++; $display("FAIL prio_drain got=%h/%b exp=00/0", pending, claim_valid); end
  endtask

  task automatic test_level_gating();
    edge_sel = 8'h00;
    src = 8'h02; tick();
    checks++; if (pending !== 8'h02) begin failures++; $display("FAIL lvl_pending got=%h exp=02", pending); end
    claim_one();
    checks++; if (pending !== 8'h00) begin failures++; $display("FAIL lvl_claimed got=%h exp=00", pending); end
    tick();
    checks++; if (pending !== 8'h00) begin failures++; $display("FAIL lvl_held got=%h exp=00", pending); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL lvl_irq got=%b exp=0", irq); end
    complete_one(3'd1);
    checks++; if (pending !== 8'h00) begin failures++; $display("FAIL lvl_complete_edge got=%h exp=00", pending); end
    tick();
    checks++; if (pending !== 8'h02) begin failures++; $display("FAIL lvl_repend got=%h exp=02", pending); end
    src = '0;
    claim_one(); complete_one(3'd1);
  endtask

  task automatic test_edge_during_service();
    edge_sel = 8'h10;
    src = 8'h10; tick(); src = '0;
    claim_one();
    src = 8'h10; tick(); src = '0;
    checks++; if (pending !== 8'h10) begin failures++; $display("FAIL eds_pending got=%h exp=10", pending); end
    checks++; if (claim_valid !== 1'b0) begin failures++; $display("FAIL eds_claim_valid got=%b exp=0", claim_valid); end
    tick();
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL eds_irq got=%b exp=0", irq); end
    complete_one(3'd4);
    checks++; if (claim_valid !== 1'b1) begin failures++; $display("FAIL eds_after_complete got=%b exp=1", claim_valid); end
    checks++; if (claim_id !== 3'd4) begin failures++; $display("FAIL eds_claim_id got=%0d exp=4", claim_id); end
    // New edge in the same cycle as the claim: the set wins but the source stays in service.
    src = 8'h10; claim_ready = 1'b1; tick(); claim_ready = 1'b0; src = '0;
    checks++; if (pending !== 8'h10) begin failures++; $display("FAIL eds_set_wins got=%h exp=10", pending); end
    checks++; if (claim_valid !== 1'b0) begin failures++; $display("FAIL eds_set_wins_valid got=%b exp=0", claim_valid); end
    complete_one(3'd4);
    claim_one(); complete_one(3'd4);
    checks++; if (pending !== 8'h00 || claim_valid !== 1'b0) begin failures++; $display("FAIL eds_drain got=%h/%b exp=00/0", pending, claim_valid); end
  endtask

  task automatic test_wake_invalid_complete();
    edge_sel = 8'h00; wfi = 1'b1;
    tick();
    src = 8'h40; tick();
    checks++; if (wake !== 1'b0 || irq !== 1'b0) begin failures++; $display("FAIL wake_early got=%b/%b exp=0/0", wake, irq); end
    tick();
    checks++; if (wake !== 1'b1) begin failures++; $display("FAIL wake_pulse got=%b exp=1", wake); end
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL wake_irq got=%b exp=1", irq); end
    tick();
    checks++; if (wake !== 1'b0) begin failures++; $display("FAIL wake_single got=%b exp=0", wake); end
    complete_one(3'd7);
    checks++; if (pending !== 8'h40) begin failures++; $display("FAIL badcpl_pending got=%h exp=40", pending); end
    checks++; if (claim_valid !== 1'b1 || claim_id !== 3'd6) begin failures++; $display("FAIL badcpl_claim got=%b/%0d exp=1/6", claim_valid, claim_id); end
    // enable cleared: pending kept, irq falls a cycle later
    enable = 8'hBF; tick();
    checks++; if (pending !== 8'h40 || claim_valid !== 1'b0) begin failures++; $display("FAIL mask_state got=%h/%b exp=40/0", pending, claim_valid); end
    tick();
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL mask_irq got=%b exp=0", irq); end
    enable = 8'hFF; wfi = 1'b0; src = '0;
    claim_one(); complete_one(3'd6);
  endtask

  task automatic test_reset_mid();
    edge_sel = 8'h05;
    src = 8'h01; tick(); src = '0;
    claim_one();
    src = 8'h05; tick(); src = '0;
    checks++; if (pending !== 8'h05) begin failures++; $display("FAIL rmid_setup got=%h exp=05", pending); end
    tick();
    checks++; if (irq !== 1'b1 || claim_id !== 3'd2) begin failures++; $display("FAIL rmid_irq got=%b/%0d exp=1/2", irq, claim_id); end
    wfi = 1'b1;
    #2 rst = 1'b1;
    #1;
    checks++; if (pending !== 8'h00) begin failures++; $display("FAIL rmid_pending got=%h exp=00", pending); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL rmid_irq_async got=%b exp=0", irq); end
    checks++; if (claim_valid !== 1'b0) begin failures++; $display("FAIL rmid_claim_valid got=%b exp=0", claim_valid); end
    @(negedge clk); rst = 1'b0;
    tick(); tick();
    checks++; if (wake !== 1'b0 || irq !== 1'b0 || pending !== 8'h00) begin failures++; $display("FAIL rmid_release got=%b/%b/%h exp=0/0/00", wake, irq, pending); end
    wfi = 1'b0;
  endtask

  initial begin
    test_reset();
    test_edge();
    test_priority();
    test_level_gating();
    test_edge_during_service();
    test_wake_invalid_complete();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
